led_pattern_shifter: RTL and testbench
======================================

Name: led_pattern_shifter

Overview:
Parametrised successor to the fixed 4-LED switch-driven shifter. It drives NUM_LEDS outputs with one of four animated patterns. A single debounced push-switch cycles through the patterns.
- Runs entirely on one clock; pattern steps are qualified by an internal tick enable rather than a divided clock.
- Sits at board top level between the raw switch pin and the LED pins.

Parameters:
- NUM_LEDS, 4, number of LED outputs; legal range >= 2.
- TICK_COUNT, 5000000, clock cycles per pattern step; legal range >= 1.
- DEBOUNCE_LIMIT, 5000000, consecutive cycles the synchronised switch must differ from the filtered value before the filtered value is updated; legal range >= 1.

Ports:
- i_clock  input  1  system clock; all logic is on its rising edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_switch  input  1  raw asynchronous push-switch; high = pressed.
- o_leds  output  NUM_LEDS  LED pattern; bit 0 = LED0.
- o_mode  output  2  current mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FILL.

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - Sampled low on an edge, reset sets o_mode=0 and o_leds=1 (only bit0 set).
  - It also clears the tick counter, debounce counter, synchroniser flops, filtered switch and previous-filtered register, and sets the bounce direction to up.
  - Reset mid-operation overrides everything on that edge.
- Synchroniser: i_switch passes through 2 flops before use.
- Debounce:
  - While the synchronised switch differs from the filtered value, the counter increments each cycle.
  - When the counter equals DEBOUNCE_LIMIT-1 and the values still differ, the filtered value takes the synchronised value on the next edge and the counter clears.
  - Whenever the values are equal, the counter clears.
- Press: press = filtered & ~filtered_prev, where filtered_prev is the filtered value registered one cycle later.
- Press latency: raw rise held stable, to o_mode change = DEBOUNCE_LIMIT+3 edges. Release produces no action.
- Tick counter:
  - Counts 0..TICK_COUNT-1 and wraps.
  - tick is asserted for the cycle in which count == TICK_COUNT-1.
  - With TICK_COUNT=1, tick is asserted every cycle.
- On press:
  - o_mode advances by 1, wrapping 3->0.
  - o_leds loads the initial value of the new mode.
  - The tick counter clears and direction is set to up.
  - A tick in the same cycle is ignored (press wins).
- On tick, with no press, o_leds steps according to the current mode:
  - ROT_L: initial 1; rotate left, with bit N-1 wrapping to bit0.
  - ROT_R: initial 1<<(N-1); rotate right, with bit0 wrapping to bit N-1.
  - BOUNCE: initial 1 with direction up.
    - Up: shift left; on reaching bit N-1, switch direction to down.
    - Down: shift right; on reaching bit0, switch direction to up.
    - End bits are shown once per pass; the period is 2N-2 ticks.
  - FILL: initial 0.
    - If not all ones, shift left with 1 inserted at bit0.
    - If all ones, the next tick clears to 0; the period is N+1 ticks.
- Outputs are registered, with no combinational path from i_switch.
- Held switch: produces exactly one press.
- Glitch: a glitch shorter than DEBOUNCE_LIMIT cycles produces no press.

Test Plan:
1. Reset behaviour (NUM_LEDS=4, TICK_COUNT=3, DEBOUNCE_LIMIT=4 for all scenarios): i_reset_n low for 2 edges, then high, switch low -> o_mode=0, o_leds=0001. Then 0010, 0100, 1000, 0001 on successive ticks, every 3 clocks.
2. Single press: i_switch high held 20 cycles -> o_mode becomes 1 exactly 7 edges after the rise, o_leds=1000. Then 0100, 0010, 0001, 1000 per tick; o_mode stays 1 while held and after release.
3. Glitch rejection: i_switch high for 3 cycles, then low -> o_mode unchanged, pattern continues uninterrupted. Then high for 4 cycles -> o_mode increments.
4. BOUNCE and FILL sequences: advance to mode 2 -> o_leds 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. Press again (mode 3) -> 0000, 0001, 0011, 0111, 1111, 0000. Press again -> o_mode=0, o_leds=0001.
5. Press coincides with tick: align press detection with count==2 -> o_leds takes the new-mode initial value, with no step applied. The next step occurs exactly 3 clocks later.
6. Mid-operation reset: i_reset_n low for 1 edge while in mode 2, direction down, with a debounce count in progress -> o_mode=0, o_leds=0001, and no spurious press after release.

Source files
------------

// File: rtl/led_pattern_shifter.sv
// Drives NUM_LEDS outputs with one of four tick-stepped patterns.
// A debounced push-switch selects the next pattern.
module led_pattern_shifter #(
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned TICK_COUNT     = 5000000,
  parameter int unsigned DEBOUNCE_LIMIT = 5000000
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_switch,
  output logic [NUM_LEDS-1:0] o_leds,
  output logic [1:0]          o_mode
);

  localparam int unsigned TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int unsigned DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    FILL   = 2'd3
  } mode_e;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                filt_q, filt_d;
  logic                filt_prev_q, filt_prev_d;
  logic [DW-1:0]       deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  mode_e               mode_q, mode_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                dir_up_q, dir_up_d;
  logic                press;
  logic                tick;
  logic [1:0]          mode_inc;

  function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
    logic [NUM_LEDS-1:0] p;
    p = '0;
    case (m)
      ROT_L:   p = NUM_LEDS'(1);
      ROT_R:   p = {1'b1, {(NUM_LEDS-1){1'b0}}};
      BOUNCE:  p = NUM_LEDS'(1);
      FILL:    p = '0;
      default: p = NUM_LEDS'(1);
    endcase
    return p;
  endfunction

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      deb_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      mode_q      <= ROT_L;
      leds_q      <= NUM_LEDS'(1);
      dir_up_q    <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      mode_q      <= mode_d;
      leds_q      <= leds_d;
      dir_up_q    <= dir_up_d;
    end
  end

  // Switch conditioning: synchroniser, debounce filter, rising-edge detect
  always_comb begin
    sync1_d     = i_switch;
    sync2_d     = sync1_q;
    filt_prev_d = filt_q;
    filt_d      = filt_q;
    deb_cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d    = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    press = filt_q & ~filt_prev_q;
  end

  // Next-state: a press reloads the pattern and restarts the tick phase,
  // taking priority over a coincident tick.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    mode_inc   = mode_q + 2'd1;
    mode_d     = mode_q;
    leds_d     = leds_q;
    dir_up_d   = dir_up_q;
    if (press) begin
      mode_d     = mode_e'(mode_inc);
      leds_d     = init_pattern(mode_e'(mode_inc));
      dir_up_d   = 1'b1;
      tick_cnt_d = '0;
    end else if (tick) begin
      case (mode_q)
        ROT_L:  leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
        ROT_R:  leds_d = {leds_q[0], leds_q[NUM_LEDS-1:1]};
        BOUNCE: begin
          if (dir_up_q) begin
            leds_d = leds_q << 1;
            if (leds_d[NUM_LEDS-1]) dir_up_d = 1'b0;
          end else begin
            leds_d = leds_q >> 1;
            if (leds_d[0]) dir_up_d = 1'b1;
          end
        end
        FILL:    leds_d = (&leds_q) ? '0 : {leds_q[NUM_LEDS-2:0], 1'b1};
        default: leds_d = leds_q;
      endcase
    end
  end

  // Outputs straight from registers
  always_comb begin
    o_mode = mode_q;
    o_leds = leds_q;
  end

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Directed self-checking bench for led_pattern_shifter
// (NUM_LEDS=4, TICK_COUNT=3, DEBOUNCE_LIMIT=4).
module tb_led_pattern_shifter;

  logic       clk;
  logic       rst_n;
  logic       sw;
  logic [3:0] leds;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  led_pattern_shifter #(
    .NUM_LEDS      (4),
    .TICK_COUNT    (3),
    .DEBOUNCE_LIMIT(4)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_switch (sw),
    .o_leds   (leds),
    .o_mode   (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each call advances exactly n rising edges, landing on a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sw    = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Press lands on the 7th edge after the rise; returns right after it.
  task automatic press();
    sw = 1'b1;
    step(7);
    sw = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] seq [0:3];
    logic [3:0] prev;
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++;
    if (leds !== 4'b0001) begin errors++; $display("FAIL reset_leds: got %b expected 0001", leds); end
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(2);
      checks++;
      if (leds !== prev) begin errors++; $display("FAIL rotl_hold[%0d]: got %b expected %b", i, leds, prev); end
      step(1);
      checks++;
      if (leds !== seq[i]) begin errors++; $display("FAIL rotl_step[%0d]: got %b expected %b", i, leds, seq[i]); end
      prev = seq[i];
    end
  endtask

  task automatic test_single_press();
    logic [3:0] seq [0:3];
    logic [3:0] prev;
    seq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    do_reset();
    sw = 1'b1;
    step(6);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL press_early: got mode %0d expected 0", mode); end
    step(1);
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL press_mode: got %0d expected 1", mode); end
    checks++;
    if (leds !== 4'b1000) begin errors++; $display("FAIL press_init: got %b expected 1000", leds); end
    prev = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(2);
      checks++;
      if (leds !== prev) begin errors++; $display("FAIL rotr_hold[%0d]: got %b expected %b", i, leds, prev); end
      step(1);
      checks++;
      if (leds !== seq[i] || mode !== 2'd1) begin
        errors++;
        $display("FAIL rotr_step[%0d]: got %b mode %0d expected %b mode 1", i, leds, mode, seq[i]);
      end
      prev = seq[i];
    end
    step(1);
    sw = 1'b0;
    step(10);
    checks++;
    if (mode !== 2'd1 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL after_release: got mode %0d leds %b expected mode 1 leds 0001", mode, leds);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    sw = 1'b1;
    step(3);
    sw = 1'b0;
    step(9);
    checks++;
    if (mode !== 2'd0 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL glitch_reject: got mode %0d leds %b expected mode 0 leds 0001", mode, leds);
    end
    sw = 1'b1;
    step(4);
    sw = 1'b0;
    step(2);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL four_cycle_early: got mode %0d expected 0", mode); end
    step(1);
    checks++;
    if (mode !== 2'd1 || leds !== 4'b1000) begin
      errors++;
      $display("FAIL four_cycle_press: got mode %0d leds %b expected mode 1 leds 1000", mode, leds);
    end
  endtask

  task automatic test_bounce_fill();
    logic [3:0] bseq [0:6];
    logic [3:0] fseq [0:4];
    bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    fseq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    do_reset();
    press();
    step(8);
    press();
    checks++;
    if (mode !== 2'd2 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_init: got mode %0d leds %b expected mode 2 leds 0001", mode, leds);
    end
    for (int i = 0; i < 7; i++) begin
      step(3);
      checks++;
      if (leds !== bseq[i]) begin errors++; $display("FAIL bounce_step[%0d]: got %b expected %b", i, leds, bseq[i]); end
    end
    press();
    checks++;
    if (mode !== 2'd3 || leds !== 4'b0000) begin
      errors++;
      $display("FAIL fill_init: got mode %0d leds %b expected mode 3 leds 0000", mode, leds);
    end
    for (int i = 0; i < 5; i++) begin
      step(3);
      checks++;
      if (leds !== fseq[i]) begin errors++; $display("FAIL fill_step[%0d]: got %b expected %b", i, leds, fseq[i]); end
    end
    press();
    checks++;
    if (mode !== 2'd0 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL mode_wrap: got mode %0d leds %b expected mode 0 leds 0001", mode, leds);
    end
  endtask

  task automatic test_press_on_tick();
    do_reset();
    step(5);
    sw = 1'b1;
    step(6);
    checks++;
    if (mode !== 2'd0 || leds !== 4'b1000) begin
      errors++;
      $display("FAIL pre_coincide: got mode %0d leds %b expected mode 0 leds 1000", mode, leds);
    end
    step(1);
    sw = 1'b0;
    checks++;
    if (mode !== 2'd1 || leds !== 4'b1000) begin
      errors++;
      $display("FAIL press_wins: got mode %0d leds %b expected mode 1 leds 1000", mode, leds);
    end
    step(2);
    checks++;
    if (leds !== 4'b1000) begin errors++; $display("FAIL coincide_hold: got %b expected 1000", leds); end
    step(1);
    checks++;
    if (leds !== 4'b0100) begin errors++; $display("FAIL coincide_next: got %b expected 0100", leds); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    press();
    step(8);
    press();
    step(12);
    checks++;
    if (mode !== 2'd2 || leds !== 4'b0100) begin
      errors++;
      $display("FAIL mid_pre_down: got mode %0d leds %b expected mode 2 leds 0100", mode, leds);
    end
    sw = 1'b1;
    step(4);
    checks++;
    if (mode !== 2'd2 || leds !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pre_reset: got mode %0d leds %b expected mode 2 leds 0010", mode, leds);
    end
    rst_n = 1'b0;
    sw    = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++;
    if (mode !== 2'd0 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset: got mode %0d leds %b expected mode 0 leds 0001", mode, leds);
    end
    step(3);
    checks++;
    if (mode !== 2'd0 || leds !== 4'b0010) begin
      errors++;
      $display("FAIL mid_after1: got mode %0d leds %b expected mode 0 leds 0010", mode, leds);
    end
    step(9);
    checks++;
    if (mode !== 2'd0 || leds !== 4'b0001) begin
      errors++;
      $display("FAIL mid_no_press: got mode %0d leds %b expected mode 0 leds 0001", mode, leds);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_bounce_fill();
    test_press_on_tick();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
